// File: rtl/sm_multiplier.sv
// Sequential sign-magnitude multiplier: one shift-add step per clock, start/busy
// handshake shared with the sign-magnitude divider, one-cycle done strobe on result.
module sm_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 start,
    output logic [2*WIDTH-1:0]   z,
    output logic                 busy,
    output logic                 done
);

    localparam int MW = WIDTH - 1;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    state_t              r_state;
    logic [MW-1:0]       r_mcand;
    logic [MW-1:0]       r_mplier;
    logic                r_sign;
    logic [2*MW-1:0]     r_pp;
    logic [CW-1:0]       r_count;
    logic [2*WIDTH-1:0]  r_z;
    logic                r_busy;
    logic                r_done;

    logic [MW-1:0]       w_addend;
    logic [MW:0]         w_sum;
    logic [2*MW-1:0]     w_pp_next;
    logic                w_last;
    logic                w_sign_final;

    // One shift-add step: add into the upper half with carry, then shift right by one.
    always_comb begin
        w_addend     = {MW{1'b0}};
        if (r_mplier[0]) begin
            w_addend = r_mcand;
        end else begin
            w_addend = {MW{1'b0}};
        end
        w_sum        = {1'b0, r_pp[2*MW-1:MW]} + {1'b0, w_addend};
        w_pp_next    = {w_sum, r_pp[MW-1:1]};
        w_last       = (r_count == CW'(MW - 1));
        w_sign_final = r_sign & (w_pp_next != {(2*MW){1'b0}});
    end

    // Control FSM and datapath registers; outputs are registered here too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_mcand  <= {MW{1'b0}};
            r_mplier <= {MW{1'b0}};
            r_sign   <= 1'b0;
            r_pp     <= {(2*MW){1'b0}};
            r_count  <= {CW{1'b0}};
            r_z      <= {(2*WIDTH){1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mcand  <= x[MW-1:0];
                        r_mplier <= y[MW-1:0];
                        r_sign   <= x[WIDTH-1] ^ y[WIDTH-1];
                        r_pp     <= {(2*MW){1'b0}};
                        r_count  <= {CW{1'b0}};
                        r_busy   <= 1'b1;
                        r_state  <= ST_CALC;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    r_pp     <= w_pp_next;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + {{(CW-1){1'b0}}, 1'b1};
                    if (w_last) begin
                        // A zero magnitude always reports a positive sign (no -0).
                        r_z     <= {w_sign_final, 1'b0, w_pp_next};
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_CALC;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign z    = r_z;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_sm_multiplier.sv
// Self-checking bench for sm_multiplier: directed vectors, randomized operands against
// an arithmetic reference, handshake corner cases and mid-operation reset.
module tb_sm_multiplier;

    logic        clk;
    logic        rst;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        start;
    logic [15:0] z;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    sm_multiplier #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .x     (x),
        .y     (y),
        .start (start),
        .z     (z),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    // Reference product from plain integer arithmetic on sign-magnitude values.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
        int unsigned p;
        logic        s;
        logic [15:0] r;
        p = int'(a[6:0]) * int'(b[6:0]);
        s = (p != 0) ? (a[7] ^ b[7]) : 1'b0;
        r = 16'(p);
        r[15] = s;
        r[14] = 1'b0;
        return r;
    endfunction

    // Launches one operation and reports what was observed; callers compare.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int cyc,
                         output logic [15:0] zo, output logic dn, output logic dn_next,
                         output logic z_moved);
        logic [15:0] z_before;
        @(negedge clk);
        x = a; y = b; start = 1'b1;
        z_before = z;
        cyc = 0;
        z_moved = 1'b0;
        do begin
            @(negedge clk);
            start = 1'b0;
            x = 8'($urandom);
            y = 8'($urandom);
            cyc++;
            if (busy === 1'b1 && z !== z_before) z_moved = 1'b1;
        end while (busy === 1'b1 && cyc < 20);
        zo = z;
        dn = done;
        @(negedge clk);
        dn_next = done;
    endtask

    task automatic check_op(input string name, input logic [7:0] a, input logic [7:0] b);
        int          cyc;
        logic [15:0] zo;
        logic        dn, dn_next, z_moved;
        logic [15:0] exp_z;
        exp_z = model(a, b);
        do_op(a, b, cyc, zo, dn, dn_next, z_moved);
        n_checks++;
        if (zo !== exp_z) begin
            n_fail++;
            $display("FAIL %s z a=%h b=%h got=%h exp=%h", name, a, b, zo, exp_z);
        end
        n_checks++;
        if (cyc !== 8) begin
            n_fail++;
            $display("FAIL %s latency got=%0d exp=8", name, cyc);
        end
        n_checks++;
        if (dn !== 1'b1 || dn_next !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_pulse got=%b%b exp=10", name, dn, dn_next);
        end
        n_checks++;
        if (z_moved !== 1'b0) begin
            n_fail++;
            $display("FAIL %s z_stable_during_calc got=1 exp=0", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; x = 8'h00; y = 8'h00;
        #12;
        n_checks++;
        if (z !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_por got z=%h busy=%b done=%b exp z=0000 busy=0 done=0", z, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        check_op("pre_reset_op", 8'h05, 8'h03);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (z !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle got z=%h busy=%b done=%b exp z=0000 busy=0 done=0", z, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed();
        check_op("dir_5x3", 8'h05, 8'h03);
        check_op("dir_m5x3", 8'h85, 8'h03);
        check_op("dir_m5xm3", 8'h85, 8'h83);
        check_op("dir_max", 8'h7F, 8'hFF);
        check_op("dir_negzero_x", 8'h80, 8'h05);
        check_op("dir_negzero_y", 8'h85, 8'h80);
        check_op("dir_maxneg_both", 8'hFF, 8'hFF);
        n_checks++;
        if (model(8'h7F, 8'hFF) !== 16'hBF01 || model(8'h85, 8'h03) !== 16'h800F) begin
            n_fail++;
            $display("FAIL model_sanity got=%h exp=bf01", model(8'h7F, 8'hFF));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            check_op("random", 8'($urandom), 8'($urandom));
        end
    endtask

    task automatic test_busy_ignore();
        int          cyc;
        int          n_done;
        logic [15:0] exp_z;
        exp_z = model(8'h93, 8'h0B);
        @(negedge clk);
        x = 8'h93; y = 8'h0B; start = 1'b1;
        cyc = 0; n_done = 0;
        do begin
            @(negedge clk);
            cyc++;
            start = (cyc == 3) ? 1'b1 : 1'b0;
            x = (cyc == 3) ? 8'h7F : 8'h00;
            y = (cyc == 3) ? 8'h7E : 8'h00;
            if (done === 1'b1) n_done++;
        end while (busy === 1'b1 && cyc < 20);
        start = 1'b0;
        n_checks++;
        if (z !== exp_z) begin
            n_fail++;
            $display("FAIL busy_ignore_z got=%h exp=%h", z, exp_z);
        end
        n_checks++;
        if (cyc !== 8) begin
            n_fail++;
            $display("FAIL busy_ignore_latency got=%0d exp=8", cyc);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ignore_single_done got done_count=%0d busy=%b exp 1 0", n_done, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a [3];
        logic [7:0]  b [3];
        int          cyc;
        for (int k = 0; k < 3; k++) begin
            a[k] = 8'($urandom);
            b[k] = 8'($urandom);
        end
        @(negedge clk);
        x = a[0]; y = b[0]; start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (busy === 1'b1 && cyc < 20);
            n_checks++;
            if (cyc !== 8 || done !== 1'b1 || z !== model(a[k], b[k])) begin
                n_fail++;
                $display("FAIL b2b_%0d got cyc=%0d done=%b z=%h exp cyc=8 done=1 z=%h",
                         k, cyc, done, z, model(a[k], b[k]));
            end
            if (k < 2) begin
                x = a[k+1]; y = b[k+1];
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_tail got done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid();
        int n_done;
        @(negedge clk);
        x = 8'h7F; y = 8'h7F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre_busy got=%b exp=1", busy);
        end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (z !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid got z=%h busy=%b done=%b exp z=0000 busy=0 done=0", z, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        n_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done !== 0 || z !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid_no_done got activity=%0d z=%h exp 0 0000", n_done, z);
        end
        check_op("post_reset", 8'hC6, 8'h0D);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
